// File: rtl/fill_counter.sv
// Pill/bottle fill sequencer: counts synchronized hopper pills into bottles and bottles into a batch.
// A pill shows in pills_bcd 3 edges after it is first sampled; outputs are registered, with no backpressure.
module fill_counter #(
  parameter int STARVE_MS = 3000,
  parameter int SWITCH_MS = 2000
) (
  input  logic        clk_1khz,
  input  logic        rst_n,
  input  logic        pill_pulse,
  input  logic        start,
  input  logic        clr,
  input  logic        abort,
  input  logic        switch_ack,
  input  logic [9:0]  target_pills,
  input  logic [6:0]  target_bottles,
  output logic        gate_open,
  output logic        bottle_full,
  output logic [11:0] pills_bcd,
  output logic [7:0]  bottles_bcd,
  output logic [2:0]  state,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    FILL   = 3'b001,
    SWITCH = 3'b010,
    DONE   = 3'b011,
    ERROR  = 3'b100
  } state_t;

  localparam int ST_W = $clog2(STARVE_MS + 1);
  localparam int SW_W = $clog2(SWITCH_MS + 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STARVE_MS - 1);
  localparam logic [SW_W-1:0] SW_LAST = SW_W'(SWITCH_MS - 1);

  state_t          st;
  logic            sync1, sync2, sync3;
  logic            pill_det;
  logic [9:0]      tp_clamp, tgt_pills, pill_cnt;
  logic [6:0]      tb_clamp, tgt_bottles, bottle_cnt;
  logic [ST_W-1:0] st_tmr;
  logic [SW_W-1:0] sw_tmr;
  logic            from_fill;

  function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
      else begin
        r[7:4]  = 4'd0;
        r[11:8] = (r[11:8] == 4'd9) ? 4'd0 : r[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      r[7:4] = (r[7:4] == 4'd9) ? 4'd0 : r[7:4] + 4'd1;
    end
    return r;
  endfunction

  assign pill_det = sync2 & ~sync3;
  assign tp_clamp = (target_pills > 10'd999) ? 10'd999 : target_pills;
  assign tb_clamp = (target_bottles > 7'd99) ? 7'd99 : target_bottles;
  assign state    = st;

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= pill_pulse;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      st          <= IDLE;
      gate_open   <= 1'b0;
      bottle_full <= 1'b0;
      pill_cnt    <= '0;
      pills_bcd   <= '0;
      bottle_cnt  <= '0;
      bottles_bcd <= '0;
      err_code    <= 2'b00;
      st_tmr      <= '0;
      sw_tmr      <= '0;
      tgt_pills   <= '0;
      tgt_bottles <= '0;
      from_fill   <= 1'b0;
    end else begin
      bottle_full <= 1'b0;
      if (clr) begin
        st          <= IDLE;
        gate_open   <= 1'b0;
        pill_cnt    <= '0;
        pills_bcd   <= '0;
        bottle_cnt  <= '0;
        bottles_bcd <= '0;
        err_code    <= 2'b00;
        st_tmr      <= '0;
        sw_tmr      <= '0;
        from_fill   <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (start && tp_clamp != '0 && tb_clamp != '0) begin
              tgt_pills   <= tp_clamp;
              tgt_bottles <= tb_clamp;
              st          <= FILL;
              gate_open   <= 1'b1;
              st_tmr      <= '0;
            end
          end
          FILL: begin
            // abort outranks a same-cycle pill, which is dropped
            if (abort) begin
              st        <= ERROR;
              gate_open <= 1'b0;
              err_code  <= 2'b11;
              from_fill <= 1'b1;
            end else if (pill_det) begin
              pill_cnt  <= pill_cnt + 10'd1;
              pills_bcd <= bcd3_inc(pills_bcd);
              st_tmr    <= '0;
              if (pill_cnt + 10'd1 == tgt_pills) begin
                bottle_full <= 1'b1;
                bottle_cnt  <= bottle_cnt + 7'd1;
                bottles_bcd <= bcd2_inc(bottles_bcd);
                gate_open   <= 1'b0;
                sw_tmr      <= '0;
                st          <= (bottle_cnt + 7'd1 == tgt_bottles) ? DONE : SWITCH;
              end
            end else if (st_tmr == ST_LAST) begin
              st        <= ERROR;
              gate_open <= 1'b0;
              err_code  <= 2'b01;
              from_fill <= 1'b1;
            end else begin
              st_tmr <= st_tmr + 1'b1;
            end
          end
          SWITCH: begin
            if (abort) begin
              st        <= ERROR;
              err_code  <= 2'b11;
              from_fill <= 1'b0;
            end else if (switch_ack) begin
              pill_cnt  <= '0;
              pills_bcd <= '0;
              st        <= FILL;
              gate_open <= 1'b1;
              st_tmr    <= '0;
            end else if (sw_tmr == SW_LAST) begin
              st        <= ERROR;
              err_code  <= 2'b10;
              from_fill <= 1'b0;
            end else begin
              sw_tmr <= sw_tmr + 1'b1;
            end
          end
          DONE: begin
            if (start) begin
              pill_cnt    <= '0;
              pills_bcd   <= '0;
              bottle_cnt  <= '0;
              bottles_bcd <= '0;
              tgt_pills   <= tp_clamp;
              tgt_bottles <= tb_clamp;
              st          <= FILL;
              gate_open   <= 1'b1;
              st_tmr      <= '0;
            end
          end
          ERROR: begin
            if (start && !abort) begin
              err_code  <= 2'b00;
              st_tmr    <= '0;
              sw_tmr    <= '0;
              st        <= from_fill ? FILL : SWITCH;
              gate_open <= from_fill;
            end
          end
          default: begin
            st        <= IDLE;
            gate_open <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fill_counter.sv
// Directed bench for fill_counter: hand-computed expectations checked with immediate assertions.
module tb_fill_counter;
  logic        clk_1khz = 1'b0;
  logic        rst_n = 1'b0;
  logic        pill_pulse = 1'b0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic        abort = 1'b0;
  logic        switch_ack = 1'b0;
  logic [9:0]  target_pills = '0;
  logic [6:0]  target_bottles = '0;
  logic        gate_open;
  logic        bottle_full;
  logic [11:0] pills_bcd;
  logic [7:0]  bottles_bcd;
  logic [2:0]  state;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_err = 0;
  int full_cnt = 0;

  fill_counter dut (
    .clk_1khz      (clk_1khz),
    .rst_n         (rst_n),
    .pill_pulse    (pill_pulse),
    .start         (start),
    .clr           (clr),
    .abort         (abort),
    .switch_ack    (switch_ack),
    .target_pills  (target_pills),
    .target_bottles(target_bottles),
    .gate_open     (gate_open),
    .bottle_full   (bottle_full),
    .pills_bcd     (pills_bcd),
    .bottles_bcd   (bottles_bcd),
    .state         (state),
    .err_code      (err_code)
  );

  always #5 clk_1khz = ~clk_1khz;

  always @(negedge clk_1khz) if (bottle_full === 1'b1) full_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk_1khz);
    #1;
  endtask

  task automatic pulse();
    pill_pulse = 1'b1;
    step(2);
    pill_pulse = 1'b0;
    step(2);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_gate"}, 32'(gate_open), 32'd0);
    chk({tag, "_full"}, 32'(bottle_full), 32'd0);
    chk({tag, "_pills"}, 32'(pills_bcd), 32'h000);
    chk({tag, "_bottles"}, 32'(bottles_bcd), 32'h00);
    chk({tag, "_err"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    int f0;
    step(2);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step(1);

    // zero pill target: start must be ignored
    target_pills = 10'd0; target_bottles = 7'd2;
    start = 1'b1; step(1); start = 1'b0; step(1);
    chk("zero_tgt_idle", 32'(state), 32'd0);
    chk("zero_tgt_gate", 32'(gate_open), 32'd0);

    // batch of 2 bottles x 3 pills
    target_pills = 10'd3;
    start = 1'b1; step(1); start = 1'b0;
    chk("start_fill", 32'(state), 32'd1);
    chk("start_gate", 32'(gate_open), 32'd1);
    target_pills = 10'd5;
    pulse();
    chk("pill1_bcd", 32'(pills_bcd), 32'h001);
    pulse(); pulse();
    chk("b1_full", 32'(full_cnt), 32'd1);
    chk("b1_state", 32'(state), 32'd2);
    chk("b1_gate", 32'(gate_open), 32'd0);
    chk("b1_pills", 32'(pills_bcd), 32'h003);
    chk("b1_bottles", 32'(bottles_bcd), 32'h01);
    pulse();
    chk("switch_ignore_pill", 32'(pills_bcd), 32'h003);
    switch_ack = 1'b1; step(1); switch_ack = 1'b0;
    chk("ack_fill", 32'(state), 32'd1);
    chk("ack_pills0", 32'(pills_bcd), 32'h000);
    pulse(); pulse(); pulse();
    chk("b2_full", 32'(full_cnt), 32'd2);
    chk("b2_bottles", 32'(bottles_bcd), 32'h02);
    chk("b2_done", 32'(state), 32'd3);
    chk("b2_gate", 32'(gate_open), 32'd0);
    chk("b2_pills_held", 32'(pills_bcd), 32'h003);

    // restart from DONE with target 12: BCD carry into tens digit
    target_pills = 10'd12; target_bottles = 7'd5;
    start = 1'b1; step(1); start = 1'b0;
    chk("done_restart", 32'(state), 32'd1);
    chk("done_clear_b", 32'(bottles_bcd), 32'h00);
    for (int i = 0; i < 10; i++) pulse();
    chk("ten_bcd", 32'(pills_bcd), 32'h010);
    chk("ten_nofull", 32'(full_cnt), 32'd2);
    pulse();
    chk("eleven_nofull", 32'(full_cnt), 32'd2);
    pulse();
    chk("twelve_full", 32'(full_cnt), 32'd3);
    chk("twelve_switch", 32'(state), 32'd2);
    chk("twelve_bcd", 32'(pills_bcd), 32'h012);

    // switch timeout
    step(1985);
    chk("sw_before_to", 32'(state), 32'd2);
    step(20);
    chk("sw_to_state", 32'(state), 32'd4);
    chk("sw_to_err", 32'(err_code), 32'd2);
    start = 1'b1; step(1); start = 1'b0;
    chk("sw_resume", 32'(state), 32'd2);
    chk("sw_resume_err", 32'(err_code), 32'd0);
    switch_ack = 1'b1; step(1); switch_ack = 1'b0;
    chk("sw_ack_fill", 32'(state), 32'd1);

    // starve timeout
    pulse();
    chk("st_pill", 32'(pills_bcd), 32'h001);
    step(2990);
    chk("st_before_to", 32'(state), 32'd1);
    step(20);
    chk("st_to_state", 32'(state), 32'd4);
    chk("st_to_err", 32'(err_code), 32'd1);
    chk("st_held_p", 32'(pills_bcd), 32'h001);
    chk("st_held_b", 32'(bottles_bcd), 32'h01);
    start = 1'b1; step(1); start = 1'b0;
    chk("st_resume", 32'(state), 32'd1);
    chk("st_resume_err", 32'(err_code), 32'd0);
    chk("st_resume_gate", 32'(gate_open), 32'd1);

    // abort coincident with a detected pill
    pill_pulse = 1'b1; step(2);
    abort = 1'b1; step(1); abort = 1'b0;
    pill_pulse = 1'b0; step(2);
    chk("abort_state", 32'(state), 32'd4);
    chk("abort_err", 32'(err_code), 32'd3);
    chk("abort_drop", 32'(pills_bcd), 32'h001);
    chk("abort_gate", 32'(gate_open), 32'd0);
    abort = 1'b1; start = 1'b1; step(2); start = 1'b0; abort = 1'b0;
    chk("err_start_abort", 32'(state), 32'd4);
    start = 1'b1; step(1); start = 1'b0;
    chk("abort_resume", 32'(state), 32'd1);

    // clr from FILL
    clr = 1'b1; step(1); clr = 1'b0;
    chk_reset_vals("clr");

    // reset when the completing pill is being counted
    target_pills = 10'd2; target_bottles = 7'd5;
    start = 1'b1; step(1); start = 1'b0;
    pulse();
    chk("rst_pre_pill", 32'(pills_bcd), 32'h001);
    f0 = full_cnt;
    pill_pulse = 1'b1; step(2);
    rst_n = 1'b0; step(1);
    pill_pulse = 1'b0; step(1);
    chk_reset_vals("midrst");
    chk("midrst_nofull", 32'(full_cnt), 32'(f0));
    rst_n = 1'b1; step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
